// File: rtl/mips_pipe_pkg.sv
// Shared types and per-stage constants for the MIPS pipeline-stage latches.
// Stage state encoding doubles as the occupancy count.
package mips_pipe_pkg;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_FULL  = 2'd2
   } state_t;

   localparam int unsigned CTRL_W_IF_ID  = 1;
   localparam int unsigned CTRL_W_ID_EX  = 16;
   localparam int unsigned CTRL_W_EX_MEM = 6;
   localparam int unsigned CTRL_W_MEM_WB = 3;

   // All-zero control bundles decode as NOP: no memory write, no register-file write.
   localparam logic [CTRL_W_EX_MEM-1:0] CTRL_RST_EX_MEM = '0;
   localparam logic [CTRL_W_MEM_WB-1:0] CTRL_RST_MEM_WB = '0;

   function automatic logic [1:0] occ_of(input state_t s);
      return s;
   endfunction

endpackage

// File: rtl/pipe_stage_reg.sv
// Payload register (data + control) with load enable and async active-low reset.
module pipe_stage_reg #(
   parameter int unsigned W = 48
) (
   input  logic         i_clk,
   input  logic         i_reset,
   input  logic         i_load,
   input  logic [W-1:0] i_d,
   output logic [W-1:0] o_q
);

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset)    o_q <= '0;
      else if (i_load) o_q <= i_d;
   end

endmodule

// File: rtl/pipe_stage_skid.sv
// Pipeline-stage latch with valid/ready handshake, optional 2-entry skid buffer,
// debug single-step gate, flush-to-bubble, occupancy and saturating stall counter.
module pipe_stage_skid
   import mips_pipe_pkg::*;
#(
   parameter int unsigned        DATA_W   = 32,
   parameter int unsigned        CTRL_W   = 16,
   parameter logic [CTRL_W-1:0]  CTRL_RST = '0,
   parameter bit                 SKID     = 1'b1,
   parameter int unsigned        CNT_W    = 32
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic              i_step,
   input  logic              i_flush_latch,
   input  logic              i_valid,
   output logic              o_ready,
   input  logic [DATA_W-1:0] i_data,
   input  logic [CTRL_W-1:0] i_ctrl,
   output logic              o_valid,
   input  logic              i_ready,
   output logic [DATA_W-1:0] o_data,
   output logic [CTRL_W-1:0] o_ctrl,
   output logic [1:0]        o_occupancy,
   output logic [CNT_W-1:0]  o_stall_cnt
);

   localparam int unsigned W = DATA_W + CTRL_W;

   state_t             state_q, state_d;
   logic               run_q;
   logic               in_fire, out_fire;
   logic               load_main, sel_skid;
   logic [W-1:0]       main_q, main_d, skid_q;
   logic [CNT_W-1:0]   stall_q;

   assign o_valid  = (state_q != ST_EMPTY);
   assign in_fire  = i_valid & o_ready;
   assign out_fire = o_valid & i_ready & i_step;

   // run_q keeps o_ready low while reset is held and for the release cycle.
   generate
      if (SKID) begin : g_skid
         logic load_skid;
         assign o_ready   = i_step & run_q & (state_q != ST_FULL);
         assign load_skid = i_step & ~i_flush_latch & (state_q == ST_ONE) & in_fire & ~out_fire;
         pipe_stage_reg #(.W(W)) u_skid (
            .i_clk  (i_clk),
            .i_reset(i_reset),
            .i_load (load_skid),
            .i_d    ({i_ctrl, i_data}),
            .o_q    (skid_q)
         );
      end else begin : g_noskid
         assign o_ready = i_step & run_q & (~o_valid | i_ready);
         assign skid_q  = '0;
      end
   endgenerate

   always_comb begin
      state_d   = state_q;
      load_main = 1'b0;
      sel_skid  = 1'b0;
      if (i_flush_latch) begin
         state_d = ST_EMPTY;
      end else if (i_step) begin
         case (state_q)
            ST_EMPTY: if (in_fire) begin
               state_d   = ST_ONE;
               load_main = 1'b1;
            end
            ST_ONE: begin
               if (in_fire && out_fire) load_main = 1'b1;
               else if (in_fire)        state_d   = ST_FULL;
               else if (out_fire)       state_d   = ST_EMPTY;
            end
            ST_FULL: if (out_fire) begin
               state_d   = ST_ONE;
               load_main = 1'b1;
               sel_skid  = 1'b1;
            end
            default: state_d = ST_EMPTY;
         endcase
      end
   end

   assign main_d = sel_skid ? skid_q : {i_ctrl, i_data};

   pipe_stage_reg #(.W(W)) u_main (
      .i_clk  (i_clk),
      .i_reset(i_reset),
      .i_load (load_main),
      .i_d    (main_d),
      .o_q    (main_q)
   );

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         state_q <= ST_EMPTY;
         run_q   <= 1'b0;
         stall_q <= '0;
      end else begin
         state_q <= state_d;
         run_q   <= 1'b1;
         if (o_valid && !i_ready && i_step && stall_q != '1)
            stall_q <= stall_q + CNT_W'(1);
      end
   end

   assign o_data      = main_q[DATA_W-1:0];
   assign o_ctrl      = o_valid ? main_q[W-1:DATA_W] : CTRL_RST;
   assign o_occupancy = occ_of(state_q);
   assign o_stall_cnt = stall_q;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed bench: SKID=1 instance (a_*) for reset/stream/backpressure/flush/step,
// SKID=0 instance (b_*) for combinational ready and stall-counter saturation.
module tb_pipe_stage_skid;

   logic        clk = 1'b0;
   logic        rst_n, step, flush;
   logic        a_valid, a_ready;
   logic [31:0] a_data;
   logic [15:0] a_ctrl;
   logic        a_o_ready, a_o_valid;
   logic [31:0] a_o_data;
   logic [15:0] a_o_ctrl;
   logic [1:0]  a_occ;
   logic [7:0]  a_stall;

   logic        b_valid, b_ready;
   logic [31:0] b_data;
   logic [15:0] b_ctrl;
   logic        b_o_ready, b_o_valid;
   logic [31:0] b_o_data;
   logic [15:0] b_o_ctrl;
   logic [1:0]  b_occ;
   logic [2:0]  b_stall;

   int n_total = 0;
   int n_pass  = 0;

   always #5 clk = ~clk;

   pipe_stage_skid #(
      .DATA_W(32), .CTRL_W(16), .CTRL_RST(16'hA5A5), .SKID(1'b1), .CNT_W(8)
   ) u_dut_a (
      .i_clk(clk), .i_reset(rst_n), .i_step(step), .i_flush_latch(flush),
      .i_valid(a_valid), .o_ready(a_o_ready), .i_data(a_data), .i_ctrl(a_ctrl),
      .o_valid(a_o_valid), .i_ready(a_ready), .o_data(a_o_data), .o_ctrl(a_o_ctrl),
      .o_occupancy(a_occ), .o_stall_cnt(a_stall)
   );

   pipe_stage_skid #(
      .DATA_W(32), .CTRL_W(16), .CTRL_RST(16'h00FF), .SKID(1'b0), .CNT_W(3)
   ) u_dut_b (
      .i_clk(clk), .i_reset(rst_n), .i_step(step), .i_flush_latch(flush),
      .i_valid(b_valid), .o_ready(b_o_ready), .i_data(b_data), .i_ctrl(b_ctrl),
      .o_valid(b_o_valid), .i_ready(b_ready), .o_data(b_o_data), .o_ctrl(b_o_ctrl),
      .o_occupancy(b_occ), .o_stall_cnt(b_stall)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_a(input logic [31:0] d);
      a_valid = 1'b1;
      a_data  = d;
      a_ctrl  = d[15:0];
   endtask

   logic [31:0] stream_v [3];

   initial begin
      stream_v[0] = 32'h10; stream_v[1] = 32'h14; stream_v[2] = 32'h18;
      rst_n = 1'b0; step = 1'b1; flush = 1'b0;
      a_valid = 1'b1; a_ready = 1'b1; a_data = 32'hDEAD; a_ctrl = 16'hBEEF;
      b_valid = 1'b0; b_ready = 1'b0; b_data = '0; b_ctrl = '0;

      // Reset held with valid input present
      tick(); tick();
      chk("rst_valid", a_o_valid, 0);
      chk("rst_ctrl",  a_o_ctrl,  16'hA5A5);
      chk("rst_occ",   a_occ,     0);
      chk("rst_stall", a_stall,   0);
      chk("rst_ready", a_o_ready, 0);
      chk("rst_data",  a_o_data,  0);
      chk("rst_b_ready", b_o_ready, 0);
      rst_n = 1'b1; a_valid = 1'b0;
      tick();
      chk("post_rst_ready", a_o_ready, 1);
      chk("post_rst_valid", a_o_valid, 0);

      // Streaming, 1-cycle latency
      a_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         push_a(stream_v[i]);
         #1;
         chk("stream_ready", a_o_ready, 1);
         tick();
         chk("stream_valid", a_o_valid, 1);
         chk("stream_data",  a_o_data,  stream_v[i]);
         chk("stream_ctrl",  a_o_ctrl,  stream_v[i] & 32'hFFFF);
      end
      a_valid = 1'b0;
      tick();
      chk("stream_drain_valid", a_o_valid, 0);
      chk("stream_drain_ctrl",  a_o_ctrl,  16'hA5A5);
      chk("stream_stall",       a_stall,   0);

      // Backpressure fills the skid
      a_ready = 1'b0;
      push_a(32'hA);
      tick();
      chk("bp_one_data", a_o_data, 32'hA);
      chk("bp_one_occ",  a_occ,    1);
      chk("bp_one_ready", a_o_ready, 1);
      push_a(32'hB);
      tick();
      chk("bp_full_occ",   a_occ,     2);
      chk("bp_full_ready", a_o_ready, 0);
      chk("bp_full_data",  a_o_data,  32'hA);
      chk("bp_stall1",     a_stall,   1);
      a_valid = 1'b0;
      tick();
      chk("bp_stall2", a_stall, 2);
      a_ready = 1'b1;
      tick();
      chk("bp_out2_data", a_o_data, 32'hB);
      chk("bp_out2_ctrl", a_o_ctrl, 16'h000B);
      chk("bp_out2_occ",  a_occ,    1);
      chk("bp_out2_stall", a_stall, 2);
      tick();
      chk("bp_empty_valid", a_o_valid, 0);

      // Flush from FULL with a new entry offered
      a_ready = 1'b0;
      push_a(32'hA); tick();
      push_a(32'hB); tick();
      chk("fl_pre_occ", a_occ, 2);
      push_a(32'hC); flush = 1'b1;
      tick();
      chk("fl_valid", a_o_valid, 0);
      chk("fl_ctrl",  a_o_ctrl,  16'hA5A5);
      chk("fl_occ",   a_occ,     0);
      chk("fl_data_kept", a_o_data, 32'hA);
      chk("fl_stall", a_stall, 4);
      chk("fl_ready_empty", a_o_ready, 1);
      tick();
      chk("fl_drop_valid", a_o_valid, 0);
      chk("fl_drop_data",  a_o_data,  32'hA);
      flush = 1'b0; a_valid = 1'b0;
      tick();
      chk("fl_after_valid", a_o_valid, 0);

      // Step gate freezes a held entry
      a_ready = 1'b0;
      push_a(32'h20);
      tick();
      a_valid = 1'b0; step = 1'b0; a_ready = 1'b1;
      #1;
      chk("step_ready_low", a_o_ready, 0);
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("step_valid", a_o_valid, 1);
         chk("step_data",  a_o_data,  32'h20);
         chk("step_ctrl",  a_o_ctrl,  16'h0020);
         chk("step_stall", a_stall,   4);
      end
      step = 1'b1;
      #1;
      chk("step_ready_high", a_o_ready, 1);
      tick();
      chk("step_consumed", a_o_valid, 0);
      chk("step_stall_end", a_stall, 4);

      // SKID=0: ready follows downstream ready combinationally
      b_ready = 1'b0; b_valid = 1'b1; b_data = 32'h30; b_ctrl = 16'h0030;
      #1;
      chk("b_empty_ready", b_o_ready, 1);
      tick();
      chk("b_one_data", b_o_data, 32'h30);
      chk("b_one_occ",  b_occ,    1);
      b_data = 32'h34; b_ctrl = 16'h0034;
      #1;
      chk("b_ready_low", b_o_ready, 0);
      b_ready = 1'b1;
      #1;
      chk("b_ready_follow", b_o_ready, 1);
      tick();
      chk("b_pass_data",  b_o_data, 32'h34);
      chk("b_pass_occ",   b_occ,    1);
      chk("b_pass_stall", b_stall,  0);

      // Stall counter saturation (3-bit)
      b_ready = 1'b0; b_valid = 1'b0;
      for (int i = 0; i < 7; i++) tick();
      chk("b_stall_7", b_stall, 7);
      for (int i = 0; i < 3; i++) tick();
      chk("b_stall_sat", b_stall, 7);
      chk("b_sat_occ",   b_occ,   1);
      b_ready = 1'b1;
      tick();
      chk("b_drain_valid", b_o_valid, 0);
      chk("b_drain_ctrl",  b_o_ctrl,  16'h00FF);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
